fmul32_share_arbiter: RTL and testbench
=======================================

Name: fmul32_share_arbiter

Overview:
Round-robin arbiter that shares one fixed-latency FMUL32 pipeline between N_REQ requesters.
- Accepts operand pairs over per-requester valid/ready.
- Issues at most one operation per cycle to the shared multiplier.
- Tracks in-flight requester IDs in a tag pipeline matched to the multiplier latency.
- Steers each result into a per-requester result register held under valid/ready.
- Sits between requesting engines and the FMUL32 top (unpack, mantissa multiply, normalization, pack).

Parameters:
N_REQ, 4, number of requesters (2..8)
LAT, 3, cycles from mul_valid asserted to mul_res_valid asserted by the shared multiplier (>=1)
ID_W, 2, requester index width, ceil(log2(N_REQ))

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  N_REQ  per-requester operand valid
req_ready  out  N_REQ  per-requester accept (one-hot or zero)
req_a  in  32*N_REQ  operand A, requester i at [32*i+31:32*i]
req_b  in  32*N_REQ  operand B, same packing
res_valid  out  N_REQ  per-requester result valid
res_ready  in  N_REQ  per-requester result accept
res_data  out  32*N_REQ  per-requester product, same packing
mul_valid  out  1  issue strobe to shared multiplier (registered)
mul_a  out  32  operand A to multiplier (registered)
mul_b  out  32  operand B to multiplier (registered)
mul_res_valid  in  1  multiplier result strobe
mul_res  in  32  multiplier product
err  out  1  sticky protocol error

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - mul_valid=0, mul_a=0, mul_b=0.
  - res_valid=0, res_data=0, busy=0, err=0.
  - Tag pipeline all invalid; rr_ptr=N_REQ-1, so requester 0 has highest priority first.
  - Reset mid-operation discards all in-flight ops; any mul_res_valid arriving after reset is ignored and does not set err.
- Eligibility: eligible[i] = req_valid[i] & ~busy[i]. busy[i] marks one outstanding op per requester, from grant until its result handshake completes.
- Grant:
  - Combinational round-robin over eligible, searching from rr_ptr+1 with wrap-around at N_REQ-1 -> 0.
  - req_ready = one-hot grant, or 0 if none eligible.
  - req_ready may depend on req_valid.
- On a handshake (req_valid[i] & req_ready[i]) at cycle t:
  - busy[i]<=1 and rr_ptr<=i.
  - At t+1: mul_valid=1, mul_a/mul_b hold requester i's operands.
  - tag pipeline stage 0 <= {1, i}.
- With no handshake: mul_valid<=0; mul_a/mul_b hold their last value. rr_ptr is unchanged.
- Tag pipeline: LAT stages shifting every cycle. Stage LAT-1 lines up with the cycle in which mul_res_valid is expected.
- Result capture: when the last tag stage is valid, with id j:
  - Expect mul_res_valid=1.
  - res_data[j]<=mul_res and res_valid[j]<=1 on the next edge.
  - End-to-end latency: handshake at t gives res_valid at t+LAT+2.
- Result drain: res_valid[j] & res_ready[j] at an edge clears res_valid[j] and busy[j]. Requester j is eligible again from the following cycle; no same-cycle regrant.
- Result slot: res_valid[j] cannot already be set at capture time, because busy blocks a second issue. If that invariant breaks, err<=1.
- err is set, and stays set until rst, on:
  - mul_res_valid=1 with the last tag stage invalid, or
  - last tag stage valid with mul_res_valid=0.
  - The mismatched result is dropped in either case.
- Throughput: one issue per cycle across different requesters; each requester gets at most one op per LAT+3 cycles.
- Simultaneous events: a capture for j and a drain for k!=j in the same cycle are both honoured. A new grant and a result capture in the same cycle are independent.

Test Plan:
- Single op: rst 2 cycles, then req_valid[0] with a=0x3FC00000 (1.5), b=0x40000000 (2.0), LAT=3, model returns 0x40400000 -> req_ready[0] at t, mul_valid at t+1, res_valid[0]=1 with res_data[0]=0x40400000 at t+5, held until res_ready[0].
- Round-robin fairness: all 4 req_valid held high, res_ready=1 -> grants 0,1,2,3 on consecutive cycles; each requester is regranted only after its result handshake; no grant is ever skipped.
- Backpressure: requester 2 with res_ready[2]=0 for 10 cycles -> res_valid[2] and res_data[2] stable, busy blocks a new req_ready[2], other requesters keep issuing.
- Wrap-around: rr_ptr=3, requesters 0 and 3 valid -> grant 0 first, then 3 in the next eligible cycle.
- Protocol error: inject mul_res_valid=1 with an empty tag pipeline -> err=1 next cycle, no res_valid change; err stays 1 until rst.
- Reset mid-op: rst asserted while 3 ops are in flight -> all res_valid=0, late mul_res_valid ignored, err=0, first grant after reset goes to requester 0.

Source files
------------

// File: rtl/fmul32_share_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FMUL32 pipeline between N_REQ requesters.
// Issue and result steering are registered; a tag pipeline tracks each in-flight requester ID.
module fmul32_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int LAT   = 3,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]      res_valid,
  input  logic [N_REQ-1:0]      res_ready,
  output logic [32*N_REQ-1:0]   res_data,
  output logic                  mul_valid,
  output logic [31:0]           mul_a,
  output logic [31:0]           mul_b,
  input  logic                  mul_res_valid,
  input  logic [31:0]           mul_res,
  output logic                  err
);

  localparam int CNT_W = $clog2(LAT + 1);

  logic [N_REQ-1:0] busy_q;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [ID_W-1:0]  issue_id_q;
  logic [LAT-1:0]   tag_v_q;
  logic [ID_W-1:0]  tag_id_q [LAT];
  logic [CNT_W-1:0] flush_cnt_q;

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  cand;
  logic             found;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic [N_REQ-1:0] drain;
  logic [ID_W-1:0]  cap_id;
  logic             cap_ok;
  logic [N_REQ-1:0] cap_set;
  logic             err_set;

  // No grants during reset, so no requester sees an accept that is then discarded.
  assign eligible  = req_valid & ~busy_q & {N_REQ{~rst}};
  assign req_ready = grant;
  assign drain     = res_valid & res_ready;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    cand     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
      if (!found && eligible[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
      end
    end
  end

  // Results still draining from before a reset land inside the flush window and are ignored.
  always_comb begin
    cap_id  = tag_id_q[LAT-1];
    cap_ok  = tag_v_q[LAT-1] & mul_res_valid & ~res_valid[cap_id];
    cap_set = '0;
    if (cap_ok) begin
      cap_set[cap_id] = 1'b1;
    end
    err_set = (tag_v_q[LAT-1] & ~mul_res_valid) |
              (tag_v_q[LAT-1] & mul_res_valid & res_valid[cap_id]) |
              (~tag_v_q[LAT-1] & mul_res_valid & (flush_cnt_q == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      rr_ptr_q    <= ID_W'(N_REQ - 1);
      issue_id_q  <= '0;
      tag_v_q     <= '0;
      for (int s = 0; s < LAT; s++) begin
        tag_id_q[s] <= '0;
      end
      flush_cnt_q <= CNT_W'(LAT);
      mul_valid   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      res_valid   <= '0;
      res_data    <= '0;
      err         <= 1'b0;
    end else begin
      if (flush_cnt_q != '0) begin
        flush_cnt_q <= flush_cnt_q - 1'b1;
      end
      mul_valid  <= found;
      issue_id_q <= grant_id;
      if (found) begin
        mul_a    <= sel_a;
        mul_b    <= sel_b;
        rr_ptr_q <= grant_id;
      end
      // Tag stage 0 pairs with the issue register, so stage LAT-1 meets mul_res_valid.
      tag_v_q[0]  <= mul_valid;
      tag_id_q[0] <= issue_id_q;
      for (int s = 1; s < LAT; s++) begin
        tag_v_q[s]  <= tag_v_q[s-1];
        tag_id_q[s] <= tag_id_q[s-1];
      end
      busy_q    <= (busy_q & ~drain) | grant;
      res_valid <= (res_valid & ~drain) | cap_set;
      for (int i = 0; i < N_REQ; i++) begin
        if (cap_set[i]) begin
          res_data[32*i +: 32] <= mul_res;
        end
      end
      err <= err | err_set;
    end
  end

endmodule

// File: tb/tb_fmul32_share_arbiter.sv
// Directed bench for fmul32_share_arbiter: behavioural multiplier model plus per-requester
// scoreboard queues filled at request handshakes and drained at result handshakes.
module tb_fmul32_share_arbiter;

  localparam int N    = 4;
  localparam int LAT  = 3;
  localparam int ID_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [32*N-1:0]   req_a;
  logic [32*N-1:0]   req_b;
  logic [N-1:0]      res_valid;
  logic [N-1:0]      res_ready;
  logic [32*N-1:0]   res_data;
  logic              mul_valid;
  logic [31:0]       mul_a;
  logic [31:0]       mul_b;
  logic              mul_res_valid;
  logic [31:0]       mul_res;
  logic              err;
  logic              inj = 1'b0;

  always #5 clk = ~clk;

  fmul32_share_arbiter #(.N_REQ(N), .LAT(LAT), .ID_W(ID_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .mul_valid     (mul_valid),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_res_valid (mul_res_valid),
    .mul_res       (mul_res),
    .err           (err)
  );

  // Truncating single-precision multiply for normal operands.
  function automatic logic [31:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    logic [22:0] m;
    int          e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    return {s, 8'(e), m};
  endfunction

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction

  // Shared multiplier model: not reset, so results from before a reset still arrive.
  logic [LAT-1:0] pv = '0;
  logic [31:0]    pr [LAT];
  assign mul_res_valid = pv[LAT-1] | inj;
  assign mul_res       = pr[LAT-1];

  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], mul_valid === 1'b1};
    pr[0] <= fmul_model(mul_a, mul_b);
    for (int s = 1; s < LAT; s++) pr[s] <= pr[s-1];
  end

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] sb_q [N][$];
  int          gnt_cnt [N] = '{default: 0};
  int          gnt_id_q [$];
  int          gnt_cyc_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: handshakes are judged at the negedge, where inputs and outputs are stable.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) sb_q[i].delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb_q[i].push_back(fmul_model(req_a[32*i +: 32], req_b[32*i +: 32]));
          gnt_cnt[i]++;
          gnt_id_q.push_back(i);
          gnt_cyc_q.push_back(cyc);
        end
        if (res_valid[i] && res_ready[i]) begin
          checks++;
          assert (sb_q[i].size() != 0) else begin
            errors++;
            $error("FAIL unexpected_result lane %0d observed %h expected none",
                   i, res_data[32*i +: 32]);
          end
          if (sb_q[i].size() != 0) chk("result_data", res_data[32*i +: 32], sb_q[i].pop_front());
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = rnd_fp();
      req_b[32*i +: 32] = rnd_fp();
    end
  endtask

  task automatic wait_res(input int lane);
    int n;
    n = 0;
    mid();
    while (res_valid[lane] !== 1'b1 && n < 20) begin
      nxt();
      mid();
      n++;
    end
    checks++;
    assert (n < 20) else begin
      errors++;
      $error("FAIL wait_res_timeout lane %0d observed %0d cycles expected <20", lane, n);
    end
  endtask

  initial begin
    int gs, n, g2, gothers;
    rst       = 1'b1;
    req_valid = '0;
    res_ready = '0;
    req_a     = '0;
    req_b     = '0;

    // Reset
    nxt();
    mid();
    chk("rst_mul_valid", mul_valid, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_req_ready", req_ready, 0);
    nxt();
    rst = 1'b0;
    mid();
    chk("rst_mul_ab", {mul_a, mul_b}, 0);
    chk("rst_res_data", res_data, 0);

    // Single op on requester 0: 1.5 * 2.0
    nxt();
    req_a[31:0] = 32'h3FC00000;
    req_b[31:0] = 32'h40000000;
    req_valid   = 4'b0001;
    mid();
    chk("single_req_ready", req_ready, 4'b0001);
    nxt();
    req_valid = '0;
    mid();
    chk("single_mul_valid", mul_valid, 1);
    chk("single_mul_a", mul_a, 32'h3FC00000);
    chk("single_mul_b", mul_b, 32'h40000000);
    for (int k = 2; k <= 4; k++) begin
      nxt();
      mid();
      chk("single_res_early", res_valid, 0);
    end
    nxt();
    mid();
    chk("single_res_valid", res_valid, 4'b0001);
    chk("single_res_data", res_data[31:0], 32'h40400000);
    for (int k = 0; k < 3; k++) begin
      nxt();
      req_valid = 4'b0001;
      mid();
      chk("single_hold_valid", res_valid, 4'b0001);
      chk("single_busy_block", req_ready, 0);
    end
    nxt();
    res_ready = 4'b0001;
    mid();
    chk("single_no_same_cycle_regrant", req_ready, 0);
    nxt();
    res_ready = '0;
    mid();
    chk("single_drained", res_valid, 0);
    chk("single_regrant", req_ready, 4'b0001);
    nxt();
    req_valid = '0;
    res_ready = '1;
    repeat (8) nxt();

    // Round-robin fairness: all requesters, results always accepted
    gs = gnt_id_q.size();
    req_valid = '1;
    for (int k = 0; k < 30; k++) begin
      rand_ops();
      nxt();
    end
    req_valid = '0;
    repeat (8) nxt();
    n = gnt_id_q.size() - gs;
    chk("rr_grant_count", n, 20);
    if (n > 0) chk("rr_first_grant", gnt_id_q[gs], 1);
    for (int k = 1; k < n; k++)
      chk("rr_order", gnt_id_q[gs+k], (gnt_id_q[gs+k-1] + 1) % N);
    for (int k = 4; k < n; k++)
      chk("rr_regrant_gap", gnt_cyc_q[gs+k] - gnt_cyc_q[gs+k-4], LAT + 3);

    // Backpressure on requester 2
    res_ready = 4'b1011;
    req_valid = '1;
    rand_ops();
    wait_res(2);
    g2      = gnt_cnt[2];
    gothers = gnt_cnt[0] + gnt_cnt[1] + gnt_cnt[3];
    for (int k = 0; k < 10; k++) begin
      chk("bp_res_valid2", res_valid[2], 1);
      if (sb_q[2].size() != 0) chk("bp_res_data2", res_data[95:64], sb_q[2][0]);
      chk("bp_busy2", req_ready[2], 0);
      nxt();
      rand_ops();
      mid();
    end
    chk("bp_no_regrant2", gnt_cnt[2] - g2, 0);
    chk("bp_others_progress", (gnt_cnt[0] + gnt_cnt[1] + gnt_cnt[3] - gothers) >= 3, 1);
    nxt();
    res_ready = '1;
    req_valid = '0;
    repeat (10) nxt();

    // Wrap-around: park the pointer at 3, then requesters 0 and 3 together
    req_valid = 4'b1000;
    nxt();
    req_valid = '0;
    repeat (8) nxt();
    req_valid = 4'b1001;
    mid();
    chk("wrap_first", req_ready, 4'b0001);
    nxt();
    mid();
    chk("wrap_second", req_ready, 4'b1000);
    nxt();
    req_valid = '0;
    repeat (8) nxt();

    // Protocol error: result strobe with nothing in flight
    mid();
    chk("perr_before", err, 0);
    nxt();
    inj = 1'b1;
    nxt();
    inj = 1'b0;
    mid();
    chk("perr_set", err, 1);
    chk("perr_no_res", res_valid, 0);
    for (int k = 0; k < 3; k++) begin
      nxt();
      mid();
      chk("perr_sticky", err, 1);
    end

    // Reset with three ops in flight
    nxt();
    rand_ops();
    req_valid = '1;
    repeat (3) nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    mid();
    chk("rmid_first_grant", req_ready, 4'b0001);
    chk("rmid_res_valid", res_valid, 0);
    chk("rmid_err", err, 0);
    for (int k = 0; k < 4; k++) begin
      nxt();
      mid();
      chk("rmid_late_ignored_err", err, 0);
      chk("rmid_late_ignored_res", res_valid, 0);
    end
    nxt();
    req_valid = '0;
    repeat (12) nxt();
    mid();
    chk("final_err", err, 0);
    chk("final_sb_empty", sb_q[0].size() + sb_q[1].size() + sb_q[2].size() + sb_q[3].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
